// File: rtl/pixel_block_packer.sv
// pixel_block_packer
//   Packs an 8-bit pixel stream into DATA_WIDTH-bit plaintext blocks for the
//   Feistel cipher. Each frame is closed with zero padding (PAD_MODE=0) or
//   PKCS#7 padding (PAD_MODE=1). PKCS#7 adds a whole pad block when a frame
//   ends exactly on a block boundary. Every finished block is presented with
//   a single-cycle tvalid pulse. The cipher cannot stall, so all flow control
//   happens on the pixel side through pix_tready.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   pix_tvalid/tdata/tlast pixel byte stream in, held by upstream until accepted
//   pix_tready             high while the packer is filling a block
//   tvalid                 1-cycle pulse, plaintext holds a new block
//   plaintext              packed block, first byte in the top byte lane
//   block_last             final block of the frame (qualified by tvalid)
//   block_count            0-based block index within the frame
//   frame_done             tvalid && block_last
module pixel_block_packer #(
  parameter int DATA_WIDTH = 256,
  parameter int PAD_MODE   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_tvalid,
  input  logic [7:0]            pix_tdata,
  input  logic                  pix_tlast,
  output logic                  pix_tready,
  output logic                  tvalid,
  output logic [DATA_WIDTH-1:0] plaintext,
  output logic                  block_last,
  output logic [CNT_WIDTH-1:0]  block_count,
  output logic                  frame_done
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [7:0] NB_BYTE = 8'(NB);

  typedef enum logic [1:0] {FILL, EMIT, PADBLK} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] slots_q, slots_d;
  logic                  pad_pending_q, pad_pending_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] plaintext_q, plaintext_d;
  logic                  block_last_q, block_last_d;
  logic [CNT_WIDTH-1:0]  block_count_q, block_count_d;
  logic                  frame_done_q, frame_done_d;

  logic                  accept;
  logic [7:0]            pad_byte;
  logic [DATA_WIDTH-1:0] merged;

  assign pix_tready  = (state_q == FILL) && !reset;
  assign tvalid      = tvalid_q;
  assign plaintext   = plaintext_q;
  assign block_last  = block_last_q;
  assign block_count = block_count_q;
  assign frame_done  = frame_done_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slots_d       = slots_q;
    pad_pending_d = pad_pending_q;
    tvalid_d      = 1'b0;
    plaintext_d   = plaintext_q;
    block_last_d  = block_last_q;
    frame_done_d  = 1'b0;
    block_count_d = block_count_q;
    accept        = pix_tvalid && pix_tready;

    // Count advances once per emitted block and restarts after the frame's last one.
    if (tvalid_q) begin
      block_count_d = block_last_q ? '0 : block_count_q + CNT_WIDTH'(1);
    end

    // Block as it would look if the current byte closes it: earlier slots from
    // the shift register, the incoming byte at idx, padding above it.
    pad_byte = (PAD_MODE != 0) ? 8'(NB - 1 - int'(idx_q)) : 8'h00;
    merged   = '0;
    for (int s = 0; s < NB; s++) begin
      if (s < int'(idx_q)) begin
        merged[DATA_WIDTH-8*(s+1) +: 8] = slots_q[DATA_WIDTH-8*(s+1) +: 8];
      end else if (s == int'(idx_q)) begin
        merged[DATA_WIDTH-8*(s+1) +: 8] = pix_tdata;
      end else begin
        merged[DATA_WIDTH-8*(s+1) +: 8] = pad_byte;
      end
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          slots_d[DATA_WIDTH-8*(int'(idx_q)+1) +: 8] = pix_tdata;
          if ((idx_q == IDX_W'(NB - 1)) || pix_tlast) begin
            plaintext_d = merged;
            idx_d       = '0;
            state_d     = EMIT;
            tvalid_d    = 1'b1;
            // A PKCS#7 frame that ends on a full block still owes a pad block,
            // so this data block cannot be the frame's last.
            if ((PAD_MODE != 0) && pix_tlast && (idx_q == IDX_W'(NB - 1))) begin
              pad_pending_d = 1'b1;
              block_last_d  = 1'b0;
              frame_done_d  = 1'b0;
            end else begin
              block_last_d  = pix_tlast;
              frame_done_d  = pix_tlast;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      EMIT: begin
        if (pad_pending_q) begin
          state_d       = PADBLK;
          plaintext_d   = {NB{NB_BYTE}};
          tvalid_d      = 1'b1;
          block_last_d  = 1'b1;
          frame_done_d  = 1'b1;
          pad_pending_d = 1'b0;
        end else begin
          state_d = FILL;
        end
      end
      PADBLK: begin
        state_d = FILL;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      idx_q         <= '0;
      slots_q       <= '0;
      pad_pending_q <= 1'b0;
      tvalid_q      <= 1'b0;
      plaintext_q   <= '0;
      block_last_q  <= 1'b0;
      block_count_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slots_q       <= slots_d;
      pad_pending_q <= pad_pending_d;
      tvalid_q      <= tvalid_d;
      plaintext_q   <= plaintext_d;
      block_last_q  <= block_last_d;
      block_count_q <= block_count_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_pixel_block_packer.sv
// Testbench for pixel_block_packer: one zero-padding instance (5-bit block
// counter so wrap-around is reachable quickly) and one PKCS#7 instance. A
// select line routes the shared pixel stream to one of them. A reference
// model turns the accepted byte stream into the list of blocks that must
// appear, one per cycle, immediately after the completing byte.
module tb_pixel_block_packer;

  localparam int NB = 32;
  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       pv    = 1'b0;
  logic [7:0] pd    = 8'h00;
  logic       pl    = 1'b0;
  logic       sel   = 1'b0;

  logic          rdy0, tv0, bl0, fd0;
  logic [DW-1:0] pt0;
  logic [4:0]    bc0;
  logic          rdy1, tv1, bl1, fd1;
  logic [DW-1:0] pt1;
  logic [15:0]   bc1;

  pixel_block_packer #(.DATA_WIDTH(DW), .PAD_MODE(0), .CNT_WIDTH(5)) u_zero (
    .clk(clk), .reset(reset), .pix_tvalid(pv && !sel), .pix_tdata(pd), .pix_tlast(pl),
    .pix_tready(rdy0), .tvalid(tv0), .plaintext(pt0), .block_last(bl0),
    .block_count(bc0), .frame_done(fd0));

  pixel_block_packer #(.DATA_WIDTH(DW), .PAD_MODE(1), .CNT_WIDTH(16)) u_pkcs (
    .clk(clk), .reset(reset), .pix_tvalid(pv && sel), .pix_tdata(pd), .pix_tlast(pl),
    .pix_tready(rdy1), .tvalid(tv1), .plaintext(pt1), .block_last(bl1),
    .block_count(bc1), .frame_done(fd1));

  logic          rdy, tv, bl, fd;
  logic [DW-1:0] pt;
  logic [15:0]   bc;
  always_comb begin
    rdy = sel ? rdy1 : rdy0;
    tv  = sel ? tv1  : tv0;
    bl  = sel ? bl1  : bl0;
    fd  = sel ? fd1  : fd0;
    pt  = sel ? pt1  : pt0;
    bc  = sel ? bc1  : {11'b0, bc0};
  end

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    int            cnt;
  } blk_t;

  blk_t       exp_q[$];
  logic [7:0] cur[$];
  int         cnt_m[2];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_blk(input logic [DW-1:0] d, input bit last);
    blk_t e;
    int   m;
    m      = sel ? 65536 : 32;
    e.data = d;
    e.last = last;
    e.cnt  = cnt_m[sel];
    exp_q.push_back(e);
    cnt_m[sel] = last ? 0 : (cnt_m[sel] + 1) % m;
  endtask

  // Reference: a block closes at NB bytes or on tlast; the unfilled tail is
  // zero or PKCS#7 (value = bytes missing); a PKCS#7 frame ending on a full
  // block gets an extra block of NB bytes of value NB.
  task automatic model_accept(input logic [7:0] b, input bit last);
    logic [DW-1:0] d;
    int            n;
    int            p;
    cur.push_back(b);
    if (cur.size() == NB || last) begin
      n = cur.size();
      p = (sel && n < NB) ? NB - n : 0;
      d = '0;
      for (int i = 0; i < NB; i++) d[DW-1-8*i -: 8] = (i < n) ? cur[i] : 8'(p);
      push_blk(d, last && !(sel && n == NB));
      if (sel && last && n == NB) push_blk({NB{8'h20}}, 1'b1);
      cur.delete();
    end
  endtask

  always @(negedge clk) begin
    blk_t e;
    if (reset) begin
      chk("ready_in_reset", rdy, 0);
      chk("tvalid_in_reset", tv, 0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tvalid", tv, 1);
      chk("plaintext", pt, e.data);
      chk("block_last", bl, e.last);
      chk("block_count", bc, e.cnt);
      chk("frame_done", fd, e.last);
      chk("ready_busy", rdy, 0);
    end else begin
      chk("tvalid_idle", tv, 0);
      chk("frame_done_idle", fd, 0);
      chk("ready_idle", rdy, 1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n  = 0;
    bit ok = 0;
    pv = 1'b1; pd = b; pl = last;
    while (!ok && n < 8) begin
      @(negedge clk);
      if (rdy) ok = 1; else n++;
    end
    chk("accept_timeout", ok, 1);
    if (!ok) begin
      pv = 1'b0; pl = 1'b0;
      return;
    end
    @(posedge clk); #1;
    pv = 1'b0; pl = 1'b0;
    model_accept(b, last);
  endtask

  task automatic idle(input int n);
    pv = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input logic [7:0] start, input int len, input bit last);
    for (int i = 0; i < len; i++) send_byte(start + 8'(i), last && (i == len - 1));
  endtask

  task automatic send_rand(input int len, input bit last, input int gapmax);
    for (int i = 0; i < len; i++) begin
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      send_byte(8'($urandom), last && (i == len - 1));
    end
  endtask

  initial begin
    int lens[8] = '{1, 33, 31, 64, 7, 2, 63, 65};
    cnt_m[0] = 0; cnt_m[1] = 0;

    // Reset values on both instances
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      chk("rst_tvalid", tv, 0);
      chk("rst_plaintext", pt, 0);
      chk("rst_block_last", bl, 0);
      chk("rst_block_count", bc, 0);
      chk("rst_frame_done", fd, 0);
      chk("rst_ready", rdy, 0);
    end
    sel = 1'b0;
    reset = 1'b0;
    idle(1);

    // Full block, zero padding
    sel = 1'b0; send_seq(8'h00, 32, 1'b1); idle(3);
    // Short PKCS#7 frame
    sel = 1'b1; send_seq(8'hA0, 5, 1'b1); idle(3);
    // PKCS#7 frame ending on a block boundary: extra pad block
    sel = 1'b1; send_seq(8'h00, 32, 1'b1); idle(4);
    // Continuous stream, 96 bytes
    sel = 1'b0; send_rand(96, 1'b0, 0);

    // Reset part-way through a block
    send_rand(10, 1'b0, 0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_tvalid", tv, 0);
    chk("mid_rst_plaintext", pt, 0);
    chk("mid_rst_block_last", bl, 0);
    chk("mid_rst_block_count", bc, 0);
    chk("mid_rst_frame_done", fd, 0);
    chk("mid_rst_ready", rdy, 0);
    cur.delete();
    exp_q.delete();
    cnt_m[0] = 0; cnt_m[1] = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
    send_rand(32, 1'b1, 0); idle(3);

    // Counter wrap: 33 blocks without tlast on the 5-bit instance
    sel = 1'b0; send_rand(33 * NB, 1'b0, 0);
    send_rand(1, 1'b1, 0); idle(3);

    // Randomized frames with gaps on both instances
    for (int f = 0; f < 16; f++) begin
      sel = 1'($urandom);
      send_rand((f < 8) ? lens[f] : $urandom_range(1, 80), 1'b1, 2);
      idle(3);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
